// File: rtl/udp_cmd_scheduler.sv
// Command queue and sequencer for UDP-driven move commands.
// Pops one command at a time, decodes it into SDRAM/SD-card selects, then waits for move_done or a timeout.
module udp_cmd_scheduler #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter int          BMP_OFFSET     = 8484,
    parameter int          IMG_SECTORS    = 1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        move_start,
    input  logic        move_done,
    output logic [1:0]  read_ch,
    output logic [1:0]  write_ch,
    output logic [1:0]  sdram_index,
    output logic [31:0] sd_rd_addr,
    output logic        busy,
    output logic        cmd_err,
    output logic        timeout_err
);

    // state  | meaning
    // IDLE   | waiting for a queued command; pops the head when present
    // DECODE | validating the command and loading channel outputs
    // START  | issuing the one-cycle move_start
    // WAIT   | waiting for move_done or the timeout
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_START  = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam int          AW            = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] IMG_SECTORS_W = 32'(IMG_SECTORS);
    localparam logic [31:0] BMP_OFFSET_W  = 32'(BMP_OFFSET);
    localparam logic [23:0] TMR_LAST      = TIMEOUT_CYCLES - 24'd1;

    // Only the low 16 bits of a command carry meaning.
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [15:0]   unused_cmd_hi;

    state_t        state;
    state_t        state_n;
    logic [15:0]   cmd_reg;
    logic [15:0]   cmd_n;
    logic [23:0]   tmr;
    logic [23:0]   tmr_n;
    logic          move_start_n;
    logic          cmd_err_n;
    logic          timeout_err_n;
    logic [1:0]    read_ch_n;
    logic [1:0]    write_ch_n;
    logic [1:0]    sdram_index_n;
    logic [31:0]   sd_rd_addr_n;
    logic [31:0]   sd_sector;
    logic [3:0]    move_type;
    logic [9:0]    sd_card_index;

    assign unused_cmd_hi = cmd_data[31:16];

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_data[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign move_type     = cmd_reg[3:0];
    assign sd_card_index = cmd_reg[15:6];
    // Unsigned 32-bit; index 0 never reaches here as a valid type-2 command.
    assign sd_sector = ({22'd0, sd_card_index} - 32'd1) * IMG_SECTORS_W + BMP_OFFSET_W;

    always_comb begin
        state_n       = state;
        cmd_n         = cmd_reg;
        tmr_n         = tmr;
        move_start_n  = 1'b0;
        cmd_err_n     = 1'b0;
        timeout_err_n = 1'b0;
        read_ch_n     = read_ch;
        write_ch_n    = write_ch;
        sdram_index_n = sdram_index;
        sd_rd_addr_n  = sd_rd_addr;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    cmd_n   = fifo_mem[rd_ptr];
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (move_type == 4'd1) begin
                    read_ch_n     = 2'd0;
                    write_ch_n    = 2'd1;
                    sdram_index_n = cmd_reg[5:4];
                    sd_rd_addr_n  = 32'd0;
                    state_n       = S_START;
                end else if (move_type == 4'd2 && sd_card_index != 10'd0) begin
                    read_ch_n     = 2'd0;
                    write_ch_n    = 2'd2;
                    sdram_index_n = cmd_reg[5:4];
                    sd_rd_addr_n  = sd_sector;
                    state_n       = S_START;
                end else begin
                    cmd_err_n     = 1'b1;
                    read_ch_n     = 2'd0;
                    write_ch_n    = 2'd0;
                    sdram_index_n = 2'd0;
                    sd_rd_addr_n  = 32'd0;
                    state_n       = S_IDLE;
                end
            end
            S_START: begin
                move_start_n = 1'b1;
                tmr_n        = 24'd0;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                tmr_n = tmr + 24'd1;
                // done takes priority over a coincident timeout
                if (move_done || tmr == TMR_LAST) begin
                    timeout_err_n = !move_done;
                    read_ch_n     = 2'd0;
                    write_ch_n    = 2'd0;
                    sdram_index_n = 2'd0;
                    sd_rd_addr_n  = 32'd0;
                    state_n       = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_reg     <= '0;
            tmr         <= '0;
            move_start  <= 1'b0;
            cmd_err     <= 1'b0;
            timeout_err <= 1'b0;
            read_ch     <= 2'd0;
            write_ch    <= 2'd0;
            sdram_index <= 2'd0;
            sd_rd_addr  <= 32'd0;
        end else begin
            state       <= state_n;
            cmd_reg     <= cmd_n;
            tmr         <= tmr_n;
            move_start  <= move_start_n;
            cmd_err     <= cmd_err_n;
            timeout_err <= timeout_err_n;
            read_ch     <= read_ch_n;
            write_ch    <= write_ch_n;
            sdram_index <= sdram_index_n;
            sd_rd_addr  <= sd_rd_addr_n;
        end
    end

endmodule

// File: tb/tb_udp_cmd_scheduler.sv
// Directed bench for udp_cmd_scheduler: latency, decode, errors, timeout, queueing and reset.
// Inputs driven and outputs sampled on the falling edge.
module tb_udp_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        move_start;
    logic        move_done;
    logic [1:0]  read_ch;
    logic [1:0]  write_ch;
    logic [1:0]  sdram_index;
    logic [31:0] sd_rd_addr;
    logic        busy;
    logic        cmd_err;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    udp_cmd_scheduler #(
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(24'd16),
        .BMP_OFFSET(8484),
        .IMG_SECTORS(1800)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .move_start(move_start),
        .move_done(move_done),
        .read_ch(read_ch),
        .write_ch(write_ch),
        .sdram_index(sdram_index),
        .sd_rd_addr(sd_rd_addr),
        .busy(busy),
        .cmd_err(cmd_err),
        .timeout_err(timeout_err)
    );

    initial begin
        #400000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    // Called on a falling edge; one push on the next rising edge.
    task automatic push_one(input logic [31:0] w);
        cmd_valid = 1'b1;
        cmd_data  = w;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (move_start !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (move_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s: move_start never seen, got %b want 1", name, move_start);
        end
    endtask

    task automatic pulse_done();
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 32'd0;
        move_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, move_start, read_ch, write_ch, sdram_index, sd_rd_addr, busy, cmd_err, timeout_err}
            !== {1'b1, 42'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b st=%b rd=%0d wr=%0d idx=%0d addr=%0d busy=%b err=%b to=%b want rdy=1 rest 0",
                     cmd_ready, move_start, read_ch, write_ch, sdram_index, sd_rd_addr, busy, cmd_err, timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_type1_latency();
        push_one(32'h0000_0051);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (move_start !== 1'b0) begin
                n_err++;
                $display("FAIL t1_early_start edge N+%0d: got %b want 0", i, move_start);
            end
            if (i == 2) begin
                n_cmp++;
                if ({read_ch, write_ch, sdram_index, sd_rd_addr, busy} !== {2'd0, 2'd1, 2'd1, 32'd0, 1'b1}) begin
                    n_err++;
                    $display("FAIL t1_channels: got rd=%0d wr=%0d idx=%0d addr=%0d busy=%b want 0 1 1 0 1",
                             read_ch, write_ch, sdram_index, sd_rd_addr, busy);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (move_start !== 1'b1) begin
            n_err++;
            $display("FAIL t1_start_at_N3: got %b want 1", move_start);
        end
        @(negedge clk);
        n_cmp++;
        if (move_start !== 1'b0) begin
            n_err++;
            $display("FAIL t1_start_one_cycle: got %b want 0", move_start);
        end
        pulse_done();
        n_cmp++;
        if ({read_ch, write_ch, sdram_index, sd_rd_addr, busy, timeout_err} !== 40'd0) begin
            n_err++;
            $display("FAIL t1_after_done: got rd=%0d wr=%0d idx=%0d addr=%0d busy=%b to=%b want all 0",
                     read_ch, write_ch, sdram_index, sd_rd_addr, busy, timeout_err);
        end
    endtask

    task automatic test_type2_addr();
        push_one(32'h0000_00E2);
        wait_start("t2_idx3_start");
        n_cmp++;
        if ({read_ch, write_ch, sdram_index, sd_rd_addr} !== {2'd0, 2'd2, 2'd2, 32'd12084}) begin
            n_err++;
            $display("FAIL t2_idx3: got rd=%0d wr=%0d idx=%0d addr=%0d want 0 2 2 12084",
                     read_ch, write_ch, sdram_index, sd_rd_addr);
        end
        pulse_done();
        push_one(32'h0000_0052);
        wait_start("t2_idx1_start");
        n_cmp++;
        if ({read_ch, write_ch, sdram_index, sd_rd_addr} !== {2'd0, 2'd2, 2'd1, 32'd8484}) begin
            n_err++;
            $display("FAIL t2_idx1: got rd=%0d wr=%0d idx=%0d addr=%0d want 0 2 1 8484",
                     read_ch, write_ch, sdram_index, sd_rd_addr);
        end
        pulse_done();
        n_cmp++;
        if ({write_ch, sdram_index, sd_rd_addr, busy} !== 37'd0) begin
            n_err++;
            $display("FAIL t2_after_done: got wr=%0d idx=%0d addr=%0d busy=%b want 0",
                     write_ch, sdram_index, sd_rd_addr, busy);
        end
    endtask

    task automatic test_done_in_start();
        push_one(32'h0000_0011);
        repeat (2) @(negedge clk);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        n_cmp++;
        if ({move_start, busy, write_ch} !== {1'b1, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL done_in_start: got st=%b busy=%b wr=%0d want 1 1 1", move_start, busy, write_ch);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_in_start_still_wait: got busy=%b want 1", busy);
        end
        pulse_done();
    endtask

    task automatic test_cmd_err();
        logic [31:0] bad [3];
        int n_pulse;
        int n_start;
        int n_chan;
        bad[0] = 32'h0000_0000;
        bad[1] = 32'h0000_0005;
        bad[2] = 32'h0000_0002;
        n_pulse = 0;
        n_start = 0;
        n_chan  = 0;
        for (int i = 0; i < 30; i++) begin
            if (cmd_err === 1'b1) n_pulse++;
            if (move_start === 1'b1) n_start++;
            if ({read_ch, write_ch, sdram_index, sd_rd_addr} !== 38'd0) n_chan++;
            cmd_valid = (i < 3);
            cmd_data  = (i < 3) ? bad[i] : 32'd0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (n_pulse != 3) begin
            n_err++;
            $display("FAIL t3_err_pulses: got %0d want 3", n_pulse);
        end
        n_cmp++;
        if (n_start != 0) begin
            n_err++;
            $display("FAIL t3_no_start: got %0d want 0", n_start);
        end
        n_cmp++;
        if (n_chan != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t3_channels_zero: got nonzero_cycles=%0d busy=%b want 0 0", n_chan, busy);
        end
    endtask

    task automatic test_timeout();
        int early;
        push_one(32'h0000_0011);
        push_one(32'h0000_0021);
        wait_start("t4_first_start");
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16 && timeout_err !== 1'b0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_err++;
            $display("FAIL t4_timeout_early: got %0d early cycles want 0", early);
        end
        n_cmp++;
        if ({timeout_err, write_ch, sdram_index, busy} !== {1'b1, 2'd0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL t4_timeout_pulse: got to=%b wr=%0d idx=%0d busy=%b want 1 0 0 0",
                     timeout_err, write_ch, sdram_index, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL t4_timeout_one_cycle: got %b want 0", timeout_err);
        end
        wait_start("t4_next_start");
        n_cmp++;
        if ({write_ch, sdram_index} !== {2'd1, 2'd2}) begin
            n_err++;
            $display("FAIL t4_next_cmd: got wr=%0d idx=%0d want 1 2", write_ch, sdram_index);
        end
        repeat (15) @(negedge clk);
        pulse_done();
        early = 0;
        for (int k = 0; k < 4; k++) begin
            if (timeout_err !== 1'b0) early++;
            @(negedge clk);
        end
        n_cmp++;
        if (early != 0 || busy !== 1'b0 || sdram_index !== 2'd0) begin
            n_err++;
            $display("FAIL t4_done_beats_timeout: got to_cycles=%0d busy=%b idx=%0d want 0 0 0", early, busy, sdram_index);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cmds [4];
        logic [35:0] exp  [4];
        int extra;
        cmds[0] = 32'h0000_0001; exp[0] = {2'd1, 2'd0, 32'd0};
        cmds[1] = 32'h0000_0021; exp[1] = {2'd1, 2'd2, 32'd0};
        cmds[2] = 32'h0000_0031; exp[2] = {2'd1, 2'd3, 32'd0};
        cmds[3] = 32'h0000_0052; exp[3] = {2'd2, 2'd1, 32'd8484};
        push_one(32'h0000_0011);
        wait_start("t5_head_start");
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_err++;
                $display("FAIL t5_ready_before_%0d: got %b want 1", i, cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_data  = cmds[i];
            @(negedge clk);
        end
        cmd_data = 32'h0000_0011;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL t5_ready_full: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL t5_no_bypass: got %b want 0", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t5_ready_after_pop: got %b want 1", cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            wait_start("t5_queued_start");
            n_cmp++;
            if ({write_ch, sdram_index, sd_rd_addr} !== exp[i]) begin
                n_err++;
                $display("FAIL t5_order_%0d: got wr=%0d idx=%0d addr=%0d want wr=%0d idx=%0d addr=%0d",
                         i, write_ch, sdram_index, sd_rd_addr, exp[i][35:34], exp[i][33:32], exp[i][31:0]);
            end
            @(negedge clk);
            pulse_done();
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (move_start === 1'b1) extra++;
            @(negedge clk);
        end
        n_cmp++;
        if (extra != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t5_drained: got extra_starts=%0d busy=%b want 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        push_one(32'h0000_0011);
        push_one(32'h0000_0021);
        wait_start("t6_start");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, move_start, read_ch, write_ch, sdram_index, sd_rd_addr, busy, cmd_err, timeout_err}
            !== {1'b1, 42'd0}) begin
            n_err++;
            $display("FAIL t6_reset_outputs: got rdy=%b st=%b rd=%0d wr=%0d idx=%0d addr=%0d busy=%b err=%b to=%b want rdy=1 rest 0",
                     cmd_ready, move_start, read_ch, write_ch, sdram_index, sd_rd_addr, busy, cmd_err, timeout_err);
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (move_start !== 1'b0 || cmd_err !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL t6_flushed: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_type1_latency();
        test_type2_addr();
        test_done_in_start();
        test_cmd_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
